// File: rtl/tcdm_pkg.sv
// Shared TCDM definitions used by the core-side request tracker and the bank-side adapter.
package tcdm_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_t;

    function automatic bit is_pow2_ge2(int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/tcdm_req_tracker.sv
// Core-side TCDM request tracker: tags outgoing loads/AMOs and releases their
// responses to the core in allocation order through a small reorder buffer.
module tcdm_req_tracker
    import tcdm_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned CoreIDWidth    = 1,
    parameter int unsigned CoreId         = 0,
    localparam int unsigned TagWidth      = $clog2(NumOutstanding),
    localparam int unsigned BeWidth       = DataWidth / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic                   req_write_i,
    input  amo_op_t                req_amo_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [BeWidth-1:0]     req_be_i,

    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_rdata_o,

    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [AddrWidth-1:0]   out_addr_o,
    output logic                   out_write_o,
    output amo_op_t                out_amo_o,
    output logic [DataWidth-1:0]   out_wdata_o,
    output logic [BeWidth-1:0]     out_be_o,
    output logic [CoreIDWidth-1:0] out_core_id_o,
    output logic [TagWidth-1:0]    out_tag_o,

    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DataWidth-1:0]   in_rdata_i,
    input  logic [TagWidth-1:0]    in_tag_i,

    output logic                   busy_o
);

    localparam logic [TagWidth:0] Depth = (TagWidth + 1)'(NumOutstanding);

    if (DataWidth != 32) begin : gen_bad_data_width
        $error("tcdm_req_tracker: only DataWidth = 32 is supported");
    end
    if (!is_pow2_ge2(NumOutstanding)) begin : gen_bad_depth
        $error("tcdm_req_tracker: NumOutstanding must be a power of two >= 2");
    end

    logic [TagWidth-1:0]       head_q, head_d;
    logic [TagWidth-1:0]       tail_q, tail_d;
    logic [TagWidth:0]         count_q, count_d;
    logic [NumOutstanding-1:0] done_q, done_d;
    logic [DataWidth-1:0]      data_q [NumOutstanding];
    logic [DataWidth-1:0]      data_d [NumOutstanding];

    logic full;
    logic alloc;
    logic pop;

    // Full is taken from the registered count only, so a same-cycle pop never frees a slot.
    assign full        = (count_q == Depth);
    assign out_valid_o = req_valid_i & (req_write_i | ~full);
    assign req_ready_o = out_ready_i & (req_write_i | ~full);
    assign alloc       = req_valid_i & req_ready_o & ~req_write_i;

    assign out_addr_o    = req_addr_i;
    assign out_write_o   = req_write_i;
    assign out_amo_o     = req_amo_i;
    assign out_wdata_o   = req_wdata_i;
    assign out_be_o      = req_be_i;
    assign out_core_id_o = CoreIDWidth'(CoreId);
    assign out_tag_o     = tail_q;

    assign in_ready_o  = 1'b1;
    assign rsp_valid_o = done_q[head_q];
    assign rsp_rdata_o = data_q[head_q];
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign busy_o      = (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        done_d  = done_q;
        data_d  = data_q;

        if (alloc) begin
            tail_d = tail_q + TagWidth'(1);
        end
        if (pop) begin
            head_d         = head_q + TagWidth'(1);
            done_d[head_q] = 1'b0;
        end
        // The popped head is already done, so an incoming response never targets it.
        if (in_valid_i) begin
            done_d[in_tag_i] = 1'b1;
            data_d[in_tag_i] = in_rdata_i;
        end

        case ({alloc, pop})
            2'b10:   count_d = count_q + (TagWidth + 1)'(1);
            2'b01:   count_d = count_q - (TagWidth + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    logic [TagWidth-1:0] rsp_offset;
    assign rsp_offset = in_tag_i - head_q;

    // A response must target an entry inside the live window that has not completed yet.
    a_rsp_tag_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        in_valid_i |-> (({1'b0, rsp_offset} < count_q) && !done_q[in_tag_i]))
        else $error("tcdm_req_tracker: response to unallocated or already-done tag %0d", in_tag_i);

endmodule
